// File: rtl/regfile_rename.sv
// Architectural register file with per-register pending-producer nicks.
// Takes renames and in-order commits from the ROB; two combinational read ports feed dispatch.
module regfile_rename #(
  parameter int REG_NUM = 32,
  parameter int NAME_W  = 5,
  parameter int NICK_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iclr,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [NAME_W-1:0] iROB_nick_regnm,
  input  logic              iROB_en,
  input  logic [NAME_W-1:0] iROB_rd_regnm,
  input  logic [DATA_W-1:0] iROB_rd_dt,
  input  logic [NICK_W-1:0] iROB_rd_nick,
  input  logic [NAME_W-1:0] iDP_rs1_regnm,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  input  logic [NAME_W-1:0] iDP_rs2_regnm,
  output logic [DATA_W-1:0] oDP_rs2_dt,
  output logic [NICK_W-1:0] oDP_rs2_nick
);

  logic [DATA_W-1:0] dt_q   [REG_NUM];
  logic [DATA_W-1:0] dt_d   [REG_NUM];
  logic [NICK_W-1:0] nick_q [REG_NUM];
  logic [NICK_W-1:0] nick_d [REG_NUM];

  logic commit_v;
  logic rename_v;
  logic commit_match;

  // x0 is never a target, so both paths exclude register name 0 up front.
  assign commit_v = rdy && !rst && !iclr && iROB_en && (iROB_rd_regnm != '0);
  assign rename_v = rdy && !rst && !iclr && iROB_nick_en && (iROB_nick_regnm != '0);
  assign commit_match = (nick_q[iROB_rd_regnm] == iROB_rd_nick);

  always_comb begin
    dt_d   = dt_q;
    nick_d = nick_q;
    if (rdy && iclr) begin
      for (int i = 0; i < REG_NUM; i++) nick_d[i] = '0;
    end else begin
      if (commit_v) begin
        dt_d[iROB_rd_regnm] = iROB_rd_dt;
        if (commit_match) nick_d[iROB_rd_regnm] = '0;
      end
      // Applied after the commit so a same-cycle rename of the same register keeps its new tag.
      if (rename_v) nick_d[iROB_nick_regnm] = iROB_nick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        dt_q[i]   <= '0;
        nick_q[i] <= '0;
      end
    end else begin
      dt_q   <= dt_d;
      nick_q <= nick_d;
    end
  end

  // Reads see pre-update state; only a tag-matching commit is forwarded, renames never are.
  always_comb begin
    oDP_rs1_dt   = dt_q[iDP_rs1_regnm];
    oDP_rs1_nick = nick_q[iDP_rs1_regnm];
    if (iDP_rs1_regnm == '0) begin
      oDP_rs1_dt   = '0;
      oDP_rs1_nick = '0;
    end else if (commit_v && (iDP_rs1_regnm == iROB_rd_regnm) && commit_match) begin
      oDP_rs1_dt   = iROB_rd_dt;
      oDP_rs1_nick = '0;
    end
  end

  always_comb begin
    oDP_rs2_dt   = dt_q[iDP_rs2_regnm];
    oDP_rs2_nick = nick_q[iDP_rs2_regnm];
    if (iDP_rs2_regnm == '0) begin
      oDP_rs2_dt   = '0;
      oDP_rs2_nick = '0;
    end else if (commit_v && (iDP_rs2_regnm == iROB_rd_regnm) && commit_match) begin
      oDP_rs2_dt   = iROB_rd_dt;
      oDP_rs2_nick = '0;
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural register-file model.
module tb_regfile_rename;

  logic        clk = 1'b0;
  logic        rst, rdy, iclr;
  logic        nick_en;
  logic [4:0]  nick, nick_regnm;
  logic        en;
  logic [4:0]  rd_regnm;
  logic [31:0] rd_dt;
  logic [4:0]  rd_nick;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_dt, rs2_dt;
  logic [4:0]  rs1_nick, rs2_nick;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: committed value and pending producer per register.
  logic [31:0] m_dt   [32];
  logic [4:0]  m_nick [32];

  always #5 clk = ~clk;

  regfile_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iclr(iclr),
    .iROB_nick_en(nick_en), .iROB_nick(nick), .iROB_nick_regnm(nick_regnm),
    .iROB_en(en), .iROB_rd_regnm(rd_regnm), .iROB_rd_dt(rd_dt), .iROB_rd_nick(rd_nick),
    .iDP_rs1_regnm(rs1), .oDP_rs1_dt(rs1_dt), .oDP_rs1_nick(rs1_nick),
    .iDP_rs2_regnm(rs2), .oDP_rs2_dt(rs2_dt), .oDP_rs2_nick(rs2_nick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; iclr = 0;
    nick_en = 0; nick = 5'd1; nick_regnm = 0;
    en = 0; rd_regnm = 0; rd_dt = 0; rd_nick = 0;
  endtask

  // What a read port must show this cycle, from the model and the current inputs.
  task automatic model_read(input logic [4:0] r, output logic [31:0] d, output logic [4:0] n);
    if (r == 0) begin
      d = 0; n = 0;
    end else if (!rst && !iclr && rdy && en && rd_regnm == r && m_nick[r] == rd_nick) begin
      d = rd_dt; n = 0;
    end else begin
      d = m_dt[r]; n = m_nick[r];
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_dt[i] = 0; m_nick[i] = 0; end
    end else if (rdy) begin
      if (iclr) begin
        for (int i = 0; i < 32; i++) m_nick[i] = 0;
      end else begin
        if (en && rd_regnm != 0) begin
          m_dt[rd_regnm] = rd_dt;
          if (m_nick[rd_regnm] == rd_nick) m_nick[rd_regnm] = 0;
        end
        if (nick_en && nick_regnm != 0) m_nick[nick_regnm] = nick;
      end
    end
  endtask

  // Called after inputs are driven at the negedge: settle, compare both ports to the model.
  task automatic settle();
    logic [31:0] d;
    logic [4:0]  n;
    #1;
    if (nick_en && nick == 0) begin
      n_checks++; n_fail++;
      $display("FAIL nick0: illegal rename with nick 0 driven");
    end
    model_read(rs1, d, n);
    chk("model_rs1_dt", rs1_dt, d);
    chk("model_rs1_nick", {27'd0, rs1_nick}, {27'd0, n});
    model_read(rs2, d, n);
    chk("model_rs2_dt", rs2_dt, d);
    chk("model_rs2_nick", {27'd0, rs2_nick}, {27'd0, n});
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_dt[i] = 'x; m_nick[i] = 'x; end
    idle();
    rs1 = 0; rs2 = 0;
    @(negedge clk);
    rst = 1;
    advance();

    // Reset state and x0 immunity.
    rs1 = 5; rs2 = 5; settle();
    chk("rst_rs1_dt", rs1_dt, 0); chk("rst_rs1_nick", {27'd0, rs1_nick}, 0);
    chk("rst_rs2_dt", rs2_dt, 0); chk("rst_rs2_nick", {27'd0, rs2_nick}, 0);
    advance();
    en = 1; rd_regnm = 0; rd_dt = 32'hDEAD; rd_nick = 0; rs1 = 0; settle();
    chk("x0_bypass_dt", rs1_dt, 0);
    advance();
    rs1 = 0; settle(); chk("x0_after_dt", rs1_dt, 0);
    advance();

    // Rename invisible same cycle, commit bypass, stored result.
    nick_en = 1; nick = 7; nick_regnm = 3; rs1 = 3; settle();
    chk("x3_rename_invisible", {27'd0, rs1_nick}, 0);
    advance();
    rs1 = 3; settle(); chk("x3_nick7", {27'd0, rs1_nick}, 7);
    advance();
    en = 1; rd_regnm = 3; rd_nick = 7; rd_dt = 32'h1234; rs1 = 3; settle();
    chk("x3_bypass_dt", rs1_dt, 32'h1234); chk("x3_bypass_nick", {27'd0, rs1_nick}, 0);
    advance();
    rs1 = 3; settle();
    chk("x3_stored_dt", rs1_dt, 32'h1234); chk("x3_stored_nick", {27'd0, rs1_nick}, 0);
    advance();

    // Older commit keeps a younger tag.
    nick_en = 1; nick = 2; nick_regnm = 4; tick();
    nick_en = 1; nick = 9; nick_regnm = 4; tick();
    en = 1; rd_regnm = 4; rd_nick = 2; rd_dt = 32'hAA; rs1 = 4; settle();
    chk("x4_nomatch_nick", {27'd0, rs1_nick}, 9); chk("x4_nomatch_dt", rs1_dt, 0);
    advance();
    rs1 = 4; rs2 = 4; settle();
    chk("x4_dt", rs2_dt, 32'hAA); chk("x4_nick", {27'd0, rs2_nick}, 9);
    advance();

    // Same-cycle commit and rename of one register.
    nick_en = 1; nick = 5; nick_regnm = 6; tick();
    en = 1; rd_regnm = 6; rd_nick = 5; rd_dt = 32'h55;
    nick_en = 1; nick = 12; nick_regnm = 6; rs1 = 6; settle();
    chk("x6_bypass_dt", rs1_dt, 32'h55); chk("x6_bypass_nick", {27'd0, rs1_nick}, 0);
    advance();
    rs1 = 6; settle();
    chk("x6_dt", rs1_dt, 32'h55); chk("x6_nick12", {27'd0, rs1_nick}, 12);
    advance();

    // Flush with simultaneous commit.
    for (int r = 1; r <= 8; r++) begin
      nick_en = 1; nick = 5'(r); nick_regnm = 5'(r); tick();
    end
    iclr = 1; en = 1; rd_regnm = 2; rd_nick = 2; rd_dt = 32'hBEEF; rs1 = 2; settle();
    chk("clr_no_bypass_nick", {27'd0, rs1_nick}, 2); chk("clr_no_bypass_dt", rs1_dt, 0);
    advance();
    for (int r = 1; r <= 8; r++) begin
      rs1 = 5'(r); rs2 = 5'(r); settle();
      chk("clr_nick", {27'd0, rs1_nick}, 0);
      advance();
    end
    rs1 = 2; settle(); chk("clr_x2_dt", rs1_dt, 0);
    advance();

    // rdy low freezes everything.
    nick_en = 1; nick = 11; nick_regnm = 10; tick();
    for (int c = 0; c < 3; c++) begin
      rdy = 0; nick_en = 1; nick = 20; nick_regnm = 10;
      en = 1; rd_regnm = 10; rd_nick = 11; rd_dt = 32'h99; rs1 = 10; settle();
      chk("hold_nick", {27'd0, rs1_nick}, 11); chk("hold_dt", rs1_dt, 0);
      advance();
    end
    rs1 = 10; settle(); chk("hold_after_nick", {27'd0, rs1_nick}, 11);
    advance();
    en = 1; rd_regnm = 10; rd_nick = 11; rd_dt = 32'h99; rs1 = 10; tick();
    rs1 = 10; settle();
    chk("resume_dt", rs1_dt, 32'h99); chk("resume_nick", {27'd0, rs1_nick}, 0);
    advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      iclr = ($urandom_range(0, 39) == 0);
      rdy  = ($urandom_range(0, 9) != 0);
      nick_en = $urandom_range(0, 1);
      nick = 5'($urandom_range(1, 31));
      nick_regnm = 5'($urandom_range(0, 15));
      en = $urandom_range(0, 1);
      rd_regnm = 5'($urandom_range(0, 15));
      rd_dt = $urandom;
      rd_nick = $urandom_range(0, 1) ? m_nick[rd_regnm] : 5'($urandom_range(0, 31));
      rs1 = $urandom_range(0, 2) == 0 ? rd_regnm : 5'($urandom_range(0, 15));
      rs2 = $urandom_range(0, 2) == 0 ? nick_regnm : 5'($urandom_range(0, 31));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags; sits on the far side of the ROB's rename and commit interfaces.
- Accepts nick allocations for an instruction's destination register and records the allocating nick as that register's pending producer.
- Accepts in-order commit writebacks from the ROB and retires the pending tag when it matches.
- Serves two combinational operand-read ports to dispatch: returns either a ready value or the nick of the pending producer.

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31).
- NAME_W, 5, register-name width.
- NICK_W, 5, ROB nick width; nick 0 is reserved to mean "no pending producer".
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- iclr  in  1  pipeline flush from ROB misprediction.
- iROB_nick_en  in  1  rename request valid.
- iROB_nick  in  NICK_W  allocated nick, 1..31.
- iROB_nick_regnm  in  NAME_W  destination register being renamed.
- iROB_en  in  1  commit writeback valid.
- iROB_rd_regnm  in  NAME_W  committed destination register.
- iROB_rd_dt  in  DATA_W  committed value.
- iROB_rd_nick  in  NICK_W  nick of the committing entry.
- iDP_rs1_regnm  in  NAME_W  read port 1 register.
- oDP_rs1_dt  out  DATA_W  read port 1 value; valid when oDP_rs1_nick==0.
- oDP_rs1_nick  out  NICK_W  read port 1 pending nick, 0 = ready.
- iDP_rs2_regnm  in  NAME_W  read port 2 register.
- oDP_rs2_dt  out  DATA_W  read port 2 value.
- oDP_rs2_nick  out  NICK_W  read port 2 pending nick.

Behaviour:
- State per register: dt[r] (DATA_W), nick[r] (NICK_W).
- Reset (rst high at posedge): all dt = 0, all nick = 0.
- Outputs are combinational and have no reset of their own. With state at reset, every read returns dt = 0, nick = 0.
- x0:
  - Never renamed and never written.
  - Reads of x0 always return dt = 0, nick = 0, regardless of inputs.
- Priority at posedge: rst > iclr > normal update. When rdy is low, nothing changes.
- iclr:
  - All nick[r] cleared to 0 in one cycle.
  - dt retained; architectural state is the committed state.
  - Any rename or commit presented in the same cycle is ignored.
- Commit (iROB_en, rdy, no rst/iclr, rd_regnm != 0):
  - dt[rd] <= iROB_rd_dt.
  - nick[rd] <= 0 only if nick[rd] == iROB_rd_nick. Otherwise a younger producer is still pending and its tag is kept.
- Rename (iROB_nick_en, rdy, no rst/iclr, regnm != 0): nick[regnm] <= iROB_nick.
- Rename and commit to the same register in the same cycle: the rename tag wins (nick = new nick) and the data write still occurs.
- Reads are zero-latency combinational and use pre-update state, with these rules:
  - A rename in the current cycle is NOT visible to reads in the same cycle. The reading instruction is the one being renamed, so its sources must not see its own destination.
  - Commit bypass: if iROB_en, commit is valid this cycle, read regnm == iROB_rd_regnm != 0, and nick[regnm] == iROB_rd_nick, the port returns dt = iROB_rd_dt and nick = 0.
  - If the tag does not match, the port returns stored dt and nick[regnm].
  - No bypass when iclr or rst is high. Port then returns stored dt and stored nick (zeros under rst, pre-flush tags under iclr).
- Both read ports are independent and may address the same register.
- Nick value 0 on iROB_nick_en is illegal; behaviour is undefined, and the bench asserts it never occurs.
- No handshake back-pressure: the file accepts one rename and one commit every cycle.

Test Plan:
- Reset, then read x5 on both ports -> dt = 0, nick = 0; write-commit to x0 (dt = 0xDEAD) -> x0 still reads 0.
- Rename x3 with nick 7, next cycle read x3 -> nick = 7. Commit x3 nick 7 dt = 0x1234 -> same-cycle read returns dt = 0x1234, nick = 0. Following cycle stored dt = 0x1234, nick = 0.
- Rename x4 nick 2, rename x4 nick 9, commit x4 nick 2 dt = 0xAA -> read x4 gives nick = 9 (tag kept); dt[4] = 0xAA stored.
- Same cycle: commit x6 nick 5 (pending tag 5) dt = 0x55 and rename x6 nick 12; read x6 same cycle -> dt = 0x55, nick = 0 (bypass, rename invisible). Next cycle -> nick = 12.
- Rename x1..x8 with nicks 1..8, assert iclr with a simultaneous commit to x2 -> all nicks read 0 next cycle; dt[2] unchanged.
- rdy low for 3 cycles with rename/commit activity on x10 -> no state change. Raising rdy resumes normal updates.
